// File: rtl/atr_io_ctrl_pkg.sv
// Register map, FSM state encodings and value helpers shared by the ATR
// sequencer and its delay FSM.
package atr_io_ctrl_pkg;

   // Configuration bus register addresses
   localparam logic [6:0] FR_ATR_CTRL    = 7'd58;
   localparam logic [6:0] FR_ATR_TXDLY   = 7'd59;
   localparam logic [6:0] FR_ATR_RXDLY   = 7'd60;
   localparam logic [6:0] FR_ATR_MASK_0  = 7'd61;
   localparam logic [6:0] FR_ATR_TXVAL_0 = 7'd62;
   localparam logic [6:0] FR_ATR_RXVAL_0 = 7'd63;
   localparam logic [6:0] FR_ATR_MASK_1  = 7'd64;
   localparam logic [6:0] FR_ATR_TXVAL_1 = 7'd65;
   localparam logic [6:0] FR_ATR_RXVAL_1 = 7'd66;
   localparam logic [6:0] FR_ATR_MAN_0   = 7'd67;
   localparam logic [6:0] FR_ATR_MAN_1   = 7'd68;

   // ATR sequencer states; the encoding is visible on atr_state
   typedef enum logic [1:0] {
      RX      = 2'd0,
      TX_WAIT = 2'd1,
      TX      = 2'd2,
      RX_WAIT = 2'd3
   } atr_state_e;

   // Manual register update: upper half of the write word selects which
   // bits of the lower half replace the old value.
   function automatic logic [15:0] masked_update(input logic [15:0] old_v,
                                                 input logic [31:0] d);
      return (old_v & ~d[31:16]) | (d[15:0] & d[31:16]);
   endfunction

   // Bits set in mask come from the ATR value, the rest from the manual value
   function automatic logic [15:0] atr_mix(input logic [15:0] mask,
                                           input logic [15:0] atrval,
                                           input logic [15:0] man);
      return (mask & atrval) | (~mask & man);
   endfunction

endpackage

// File: rtl/atr_io_ctrl_if.sv
// Configuration bus, TX activity level and the pin-block output values of
// the ATR sequencer, bundled so the host side sees a single port.
interface atr_io_ctrl_if;
   logic [6:0]  serial_addr;
   logic [31:0] serial_data;
   logic        serial_strobe;
   logic        tx_active;
   logic [15:0] reg_0;
   logic [15:0] reg_1;
   logic [1:0]  atr_state;

   // Host / stimulus side
   modport master (
      output serial_addr, serial_data, serial_strobe, tx_active,
      input  reg_0, reg_1, atr_state
   );

   // Sequencer side
   modport slave (
      input  serial_addr, serial_data, serial_strobe, tx_active,
      output reg_0, reg_1, atr_state
   );
endinterface

// File: rtl/atr_io_ctrl_atr_delay_fsm.sv
// Four-state T/R sequencer with programmable turn-on and turn-off delays.
// Delays are sampled only when a wait state is entered.
module atr_delay_fsm
   import atr_io_ctrl_pkg::*;
#(
   parameter int DLY_W = 12
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             tx_req_i,
   input  logic             enable_i,
   input  logic [DLY_W-1:0] txdly_i,
   input  logic [DLY_W-1:0] rxdly_i,
   output atr_state_e       state_o
);

   atr_state_e       state_q, state_d;
   logic [DLY_W-1:0] cnt_q, cnt_d;

   // State and delay counter registers
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= RX;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state and counter logic; an abort request beats counter expiry
   // NOTE: hold-by-default assignments come first so no path leaves a
   // variable unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (!enable_i) begin
         state_d = RX;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            RX: begin
               if (tx_req_i) begin
                  if (txdly_i == '0) begin
                     state_d = TX;
                  end else begin
                     state_d = TX_WAIT;
                     cnt_d   = txdly_i;
                  end
               end
            end
            TX_WAIT: begin
               if (!tx_req_i) begin
                  state_d = RX;
                  cnt_d   = '0;
               end else if (cnt_q == DLY_W'(1)) begin
                  state_d = TX;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q - DLY_W'(1);
               end
            end
            TX: begin
               if (!tx_req_i) begin
                  if (rxdly_i == '0) begin
                     state_d = RX;
                  end else begin
                     state_d = RX_WAIT;
                     cnt_d   = rxdly_i;
                  end
               end
            end
            RX_WAIT: begin
               if (tx_req_i) begin
                  state_d = TX;
                  cnt_d   = '0;
               end else if (cnt_q == DLY_W'(1)) begin
                  state_d = RX;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q - DLY_W'(1);
               end
            end
            default: begin
               state_d = RX;
               cnt_d   = '0;
            end
         endcase
      end
   end

   assign state_o = state_q;

endmodule

// File: rtl/atr_io_ctrl.sv
// ATR sequencer top: configuration register file, delay FSM and the
// registered per-bank output mux feeding the GPIO pin block.
module atr_io_ctrl
   import atr_io_ctrl_pkg::*;
#(
   parameter int DLY_W = 12
) (
   input  logic          clock,
   input  logic          reset_n,
   atr_io_ctrl_if.slave  bus
);

   logic [1:0]       ctrl_q;          // [0] enable, [1] force_tx
   logic [DLY_W-1:0] txdly_q;
   logic [DLY_W-1:0] rxdly_q;
   logic [15:0]      mask_q  [2];
   logic [15:0]      txval_q [2];
   logic [15:0]      rxval_q [2];
   logic [15:0]      man_q   [2];
   logic [15:0]      reg_q   [2];
   logic [15:0]      reg_d   [2];

   logic       ctrl_wr;
   logic       enable_now;
   logic       tx_req;
   logic       sel_tx;
   atr_state_e fsm_state;

   assign ctrl_wr = bus.serial_strobe && (bus.serial_addr == FR_ATR_CTRL);

   // Clearing enable must drop the FSM to RX on the write edge itself, so
   // the FSM sees the value being written rather than the stored one.
   assign enable_now = ctrl_wr ? bus.serial_data[0] : ctrl_q[0];
   assign tx_req     = bus.tx_active | ctrl_q[1];

   // Configuration register file writes
   // NOTE: the register file is small enough that resetting every entry is
   // cheap, and it guarantees the pins come up at a known value.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ctrl_q  <= '0;
         txdly_q <= '0;
         rxdly_q <= '0;
         for (int k = 0; k < 2; k++) begin
            mask_q[k]  <= '0;
            txval_q[k] <= '0;
            rxval_q[k] <= '0;
            man_q[k]   <= '0;
         end
      end else if (bus.serial_strobe) begin
         case (bus.serial_addr)
            FR_ATR_CTRL:    ctrl_q     <= bus.serial_data[1:0];
            FR_ATR_TXDLY:   txdly_q    <= bus.serial_data[DLY_W-1:0];
            FR_ATR_RXDLY:   rxdly_q    <= bus.serial_data[DLY_W-1:0];
            FR_ATR_MASK_0:  mask_q[0]  <= bus.serial_data[15:0];
            FR_ATR_TXVAL_0: txval_q[0] <= bus.serial_data[15:0];
            FR_ATR_RXVAL_0: rxval_q[0] <= bus.serial_data[15:0];
            FR_ATR_MASK_1:  mask_q[1]  <= bus.serial_data[15:0];
            FR_ATR_TXVAL_1: txval_q[1] <= bus.serial_data[15:0];
            FR_ATR_RXVAL_1: rxval_q[1] <= bus.serial_data[15:0];
            FR_ATR_MAN_0:   man_q[0]   <= masked_update(man_q[0], bus.serial_data);
            FR_ATR_MAN_1:   man_q[1]   <= masked_update(man_q[1], bus.serial_data);
            default: ;
         endcase
      end
   end

   atr_delay_fsm #(.DLY_W(DLY_W)) u_fsm (
      .clock    (clock),
      .reset_n  (reset_n),
      .tx_req_i (tx_req),
      .enable_i (enable_now),
      .txdly_i  (txdly_q),
      .rxdly_i  (rxdly_q),
      .state_o  (fsm_state)
   );

   // TX values are presented while transmitting and through the turn-off tail
   assign sel_tx = (fsm_state == TX) || (fsm_state == RX_WAIT);

   // Per-bank output value from the current state and stored configuration
   always_comb begin
      for (int k = 0; k < 2; k++) begin
         reg_d[k] = man_q[k];
         if (ctrl_q[0]) begin
            reg_d[k] = atr_mix(mask_q[k], sel_tx ? txval_q[k] : rxval_q[k], man_q[k]);
         end
      end
   end

   // Output registers, one edge behind the FSM state
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         reg_q[0] <= '0;
         reg_q[1] <= '0;
      end else begin
         reg_q[0] <= reg_d[0];
         reg_q[1] <= reg_d[1];
      end
   end

   assign bus.reg_0     = reg_q[0];
   assign bus.reg_1     = reg_q[1];
   assign bus.atr_state = fsm_state;

endmodule

// File: tb/tb_atr_io_ctrl.sv
// Self-checking bench for atr_io_ctrl: directed scenarios with literal
// expectations, then randomized traffic, all compared every cycle against
// a behavioural model of the sequencer.
module tb_atr_io_ctrl;
   import atr_io_ctrl_pkg::*;

   localparam int DLY_W = 12;
   localparam int M_RX = 0, M_TXW = 1, M_TX = 2, M_RXW = 3;

   logic clock   = 1'b0;
   logic reset_n = 1'b0;

   atr_io_ctrl_if bus ();

   atr_io_ctrl #(.DLY_W(DLY_W)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_errors = 0;

   // Behavioural model state
   logic        m_enable, m_force;
   int          m_txdly, m_rxdly;
   logic [15:0] m_mask [2], m_txval [2], m_rxval [2], m_man [2];
   logic [15:0] m_reg [2];
   int          m_state;
   int          m_wait_len, m_waited;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_enable = 1'b0; m_force = 1'b0;
      m_txdly = 0; m_rxdly = 0;
      for (int k = 0; k < 2; k++) begin
         m_mask[k] = '0; m_txval[k] = '0; m_rxval[k] = '0; m_man[k] = '0; m_reg[k] = '0;
      end
      m_state = M_RX; m_wait_len = 0; m_waited = 0;
   endtask

   // Advance the model by one rising edge using the inputs present at that edge
   task automatic model_step();
      logic        wr, en_now, tx_req;
      logic [6:0]  a;
      logic [31:0] d;
      logic [15:0] atr;
      int          nxt;
      wr     = bus.serial_strobe;
      a      = bus.serial_addr;
      d      = bus.serial_data;
      tx_req = bus.tx_active | m_force;
      en_now = (wr && a == FR_ATR_CTRL) ? d[0] : m_enable;

      // Outputs follow the state and configuration as they were before the edge
      for (int k = 0; k < 2; k++) begin
         atr = (m_state == M_TX || m_state == M_RXW) ? m_txval[k] : m_rxval[k];
         m_reg[k] = m_enable ? ((m_mask[k] & atr) | (~m_mask[k] & m_man[k])) : m_man[k];
      end

      // Sequencer: a wait lasts wait_len edges unless the request flips
      nxt = m_state;
      if (!en_now) begin
         nxt = M_RX;
      end else if (m_state == M_RX) begin
         if (tx_req) begin
            if (m_txdly == 0) nxt = M_TX;
            else begin nxt = M_TXW; m_wait_len = m_txdly; m_waited = 0; end
         end
      end else if (m_state == M_TXW) begin
         if (!tx_req) nxt = M_RX;
         else begin
            m_waited++;
            if (m_waited == m_wait_len) nxt = M_TX;
         end
      end else if (m_state == M_TX) begin
         if (!tx_req) begin
            if (m_rxdly == 0) nxt = M_RX;
            else begin nxt = M_RXW; m_wait_len = m_rxdly; m_waited = 0; end
         end
      end else begin
         if (tx_req) nxt = M_TX;
         else begin
            m_waited++;
            if (m_waited == m_wait_len) nxt = M_RX;
         end
      end
      m_state = nxt;

      if (wr) begin
         case (a)
            FR_ATR_CTRL:    begin m_enable = d[0]; m_force = d[1]; end
            FR_ATR_TXDLY:   m_txdly = int'(d[DLY_W-1:0]);
            FR_ATR_RXDLY:   m_rxdly = int'(d[DLY_W-1:0]);
            FR_ATR_MASK_0:  m_mask[0]  = d[15:0];
            FR_ATR_TXVAL_0: m_txval[0] = d[15:0];
            FR_ATR_RXVAL_0: m_rxval[0] = d[15:0];
            FR_ATR_MASK_1:  m_mask[1]  = d[15:0];
            FR_ATR_TXVAL_1: m_txval[1] = d[15:0];
            FR_ATR_RXVAL_1: m_rxval[1] = d[15:0];
            FR_ATR_MAN_0:   m_man[0] = (m_man[0] & ~d[31:16]) | (d[15:0] & d[31:16]);
            FR_ATR_MAN_1:   m_man[1] = (m_man[1] & ~d[31:16]) | (d[15:0] & d[31:16]);
            default: ;
         endcase
      end
   endtask

   // One clock: model and DUT advance together, outputs compared after the edge
   task automatic cycle();
      @(posedge clock);
      model_step();
      #1;
      check("reg_0",     32'(bus.reg_0),     32'(m_reg[0]));
      check("reg_1",     32'(bus.reg_1),     32'(m_reg[1]));
      check("atr_state", 32'(bus.atr_state), 32'(m_state));
   endtask

   task automatic write_reg(input logic [6:0] addr, input logic [31:0] data);
      bus.serial_addr   = addr;
      bus.serial_data   = data;
      bus.serial_strobe = 1'b1;
      cycle();
      bus.serial_strobe = 1'b0;
      bus.serial_addr   = 7'd0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [6:0]  ra;
      logic [31:0] rd;
      int          r;

      bus.serial_addr   = 7'd0;
      bus.serial_data   = 32'd0;
      bus.serial_strobe = 1'b0;
      bus.tx_active     = 1'b0;
      model_reset();

      // Reset state
      #20;
      check("reset reg_0", 32'(bus.reg_0), 32'h0);
      check("reset reg_1", 32'(bus.reg_1), 32'h0);
      check("reset state", 32'(bus.atr_state), 32'h0);
      #3 reset_n = 1'b1;
      cycle();

      // Masked manual write reaches the pins two edges after the strobe
      write_reg(FR_ATR_MAN_0, 32'h00FF_00A5);
      check("man0 write edge", 32'(bus.reg_0), 32'h0);
      cycle();
      check("man0 visible", 32'(bus.reg_0), 32'h00A5);

      // Turn-on delay of 5
      write_reg(FR_ATR_CTRL, 32'h1);
      write_reg(FR_ATR_MASK_0, 32'hFFFF);
      write_reg(FR_ATR_RXVAL_0, 32'h0001);
      write_reg(FR_ATR_TXVAL_0, 32'h0002);
      write_reg(FR_ATR_TXDLY, 32'd5);
      cycle();
      cycle();
      check("rx value", 32'(bus.reg_0), 32'h0001);
      bus.tx_active = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cycle();
         check("tx_wait state", 32'(bus.atr_state), 32'd1);
         check("tx_wait reg_0", 32'(bus.reg_0), 32'h0001);
      end
      cycle();
      check("tx state", 32'(bus.atr_state), 32'd2);
      check("tx reg_0 lag", 32'(bus.reg_0), 32'h0001);
      cycle();
      check("tx reg_0", 32'(bus.reg_0), 32'h0002);

      // Turn-off delay of 3
      write_reg(FR_ATR_RXDLY, 32'd3);
      bus.tx_active = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cycle();
         check("rx_wait state", 32'(bus.atr_state), 32'd3);
         check("rx_wait reg_0", 32'(bus.reg_0), 32'h0002);
      end
      cycle();
      check("back to rx", 32'(bus.atr_state), 32'd0);
      cycle();
      check("rx reg_0", 32'(bus.reg_0), 32'h0001);

      // Short pulse aborts the turn-on wait
      write_reg(FR_ATR_TXDLY, 32'd10);
      bus.tx_active = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cycle();
         check("abort wait state", 32'(bus.atr_state), 32'd1);
      end
      bus.tx_active = 1'b0;
      cycle();
      check("abort to rx", 32'(bus.atr_state), 32'd0);
      for (int i = 0; i < 3; i++) begin
         cycle();
         check("abort reg_0", 32'(bus.reg_0), 32'h0001);
      end

      // Re-request during the turn-off wait returns straight to TX
      write_reg(FR_ATR_TXDLY, 32'd0);
      write_reg(FR_ATR_RXDLY, 32'd8);
      bus.tx_active = 1'b1;
      cycle();
      check("zero delay tx", 32'(bus.atr_state), 32'd2);
      cycle();
      bus.tx_active = 1'b0;
      cycle();
      check("rewait state a", 32'(bus.atr_state), 32'd3);
      check("rewait reg_0 a", 32'(bus.reg_0), 32'h0002);
      cycle();
      check("rewait reg_0 b", 32'(bus.reg_0), 32'h0002);
      bus.tx_active = 1'b1;
      cycle();
      check("retx state", 32'(bus.atr_state), 32'd2);
      check("retx reg_0", 32'(bus.reg_0), 32'h0002);
      cycle();
      check("retx reg_0 b", 32'(bus.reg_0), 32'h0002);

      // Bank 1 masking with force_tx, then disable
      bus.tx_active = 1'b0;
      write_reg(FR_ATR_MASK_1, 32'h00F0);
      write_reg(FR_ATR_MAN_1, 32'hFFFF_1234);
      write_reg(FR_ATR_TXVAL_1, 32'hFFFF);
      write_reg(FR_ATR_CTRL, 32'h3);
      cycle();
      cycle();
      check("force tx state", 32'(bus.atr_state), 32'd2);
      check("force tx reg_1", 32'(bus.reg_1), 32'h12F4);
      write_reg(FR_ATR_CTRL, 32'h0);
      check("disable state", 32'(bus.atr_state), 32'd0);
      cycle();
      check("disable reg_1", 32'(bus.reg_1), 32'h1234);
      check("disable reg_0", 32'(bus.reg_0), 32'h00A5);

      // Asynchronous reset in the middle of a turn-on wait
      write_reg(FR_ATR_CTRL, 32'h1);
      write_reg(FR_ATR_TXDLY, 32'd5);
      bus.tx_active = 1'b1;
      cycle();
      cycle();
      check("pre-reset state", 32'(bus.atr_state), 32'd1);
      #3 reset_n = 1'b0;
      #1;
      model_reset();
      check("async reset state", 32'(bus.atr_state), 32'd0);
      check("async reset reg_0", 32'(bus.reg_0), 32'h0);
      check("async reset reg_1", 32'(bus.reg_1), 32'h0);
      @(posedge clock);
      @(posedge clock);
      #2 reset_n = 1'b1;
      cycle();
      check("post-reset state", 32'(bus.atr_state), 32'd0);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 7) == 0) bus.tx_active = ~bus.tx_active;
         if ($urandom_range(0, 3) == 0) begin
            r  = int'($urandom_range(0, 11));
            ra = (r == 11) ? 7'($urandom_range(0, 127)) : 7'(58 + r);
            rd = $urandom;
            if (ra == FR_ATR_TXDLY || ra == FR_ATR_RXDLY) rd = 32'($urandom_range(0, 6));
            if (ra == FR_ATR_CTRL) rd[0] = ($urandom_range(0, 3) != 0);
            write_reg(ra, rd);
         end else begin
            cycle();
         end
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/atr_io_ctrl.md
# atr_io_ctrl

Automatic transmit/receive (ATR) sequencer for the daughterboard GPIO banks. It tracks the transmit path's activity and walks a four-state FSM with programmable turn-on and turn-off delays. From the FSM state it produces the `reg_0`/`reg_1` output values that the bidirectional pin block drives onto `io_0`/`io_1`. It sits between the serial configuration bus and the pin block, so antenna T/R switches and PA enables change without host round-trips.

## Interface
- `DLY_W`, default 12: width of the delay counters and delay registers.
- `clock`  in  1: system clock; all state updates on the rising edge.
- `reset_n`  in  1: reset, asynchronous, active-low.
- `serial_addr`  in  7: configuration bus address.
- `serial_data`  in  32: configuration bus write data.
- `serial_strobe`  in  1: one-cycle write qualifier.
- `tx_active`  in  1: level; high while the TX chain holds samples to send, synchronous to `clock`.
- `reg_0`  out  16: bank 0 output value to the pin block; registered.
- `reg_1`  out  16: bank 1 output value; registered.
- `atr_state`  out  2: current FSM state; registered.

## Operation
- Config registers are written when `serial_strobe` is high and `serial_addr` matches. Every register resets to 0.
- `FR_ATR_CTRL`:
  - bit0 `enable`.
  - bit1 `force_tx`; the FSM uses `tx_req = tx_active | force_tx`.
- `FR_ATR_TXDLY[DLY_W-1:0]`: turn-on delay in cycles.
- `FR_ATR_RXDLY[DLY_W-1:0]`: turn-off delay in cycles.
- `FR_ATR_MASK_k`, `FR_ATR_TXVAL_k`, `FR_ATR_RXVAL_k` for k = 0, 1: 16-bit values in data[15:0].
- `FR_ATR_MAN_k`: masked manual write. New value = `(old & ~d[31:16]) | (d[15:0] & d[31:16])`.
- FSM states and encodings: `RX`=0, `TX_WAIT`=1, `TX`=2, `RX_WAIT`=3.
- `RX`:
  - `tx_req` with TXDLY=0 → `TX`.
  - `tx_req` with TXDLY>0 → `TX_WAIT`, counter loaded with TXDLY.
- `TX_WAIT`:
  - `!tx_req` → `RX` (abort).
  - Otherwise the counter decrements each cycle. When the counter equals 1 → `TX`.
- `TX`:
  - `!tx_req` with RXDLY=0 → `RX`.
  - `!tx_req` with RXDLY>0 → `RX_WAIT`, counter loaded with RXDLY.
- `RX_WAIT`:
  - `tx_req` → `TX` immediately; no turn-on delay is re-applied.
  - Otherwise the counter decrements. When the counter equals 1 → `RX`.
- ATR value selection:
  - `RX` and `TX_WAIT` select RXVAL.
  - `TX` and `RX_WAIT` select TXVAL.
- Output: `reg_k = enable ? (MASK_k & atrval_k) | (~MASK_k & MAN_k) : MAN_k`.
- `enable`=0 holds the FSM in `RX` and clears the counter.
- Delay registers are sampled only at counter load. A write during a wait does not alter the running count.

## Timing
- Reset state: `atr_state`=0, `reg_0`=`reg_1`=0x0000, counter 0.
- A config write at edge N is visible in the register after edge N. It affects `reg_k` after edge N+1.
- FSM latency:
  - `tx_req` first sampled high at edge N with TXDLY=D≥1: `atr_state`=`TX_WAIT` after edge N, `TX` after edge N+D.
  - With D=0: `TX` after edge N.
- Output latency: `reg_k` reflects the state one edge after `atr_state` changes. TX values therefore appear at edge N+D+1.
- Turn-off is symmetric using RXDLY.
- If the abort condition and counter=1 occur in the same cycle in a wait state, the abort wins.
- Clearing `enable` mid-sequence gives `atr_state`=`RX` after the write edge. Outputs show MAN one edge later.
- Reset assertion mid-sequence returns everything to reset values immediately (asynchronous). The FSM restarts from `RX` on the first edge after release.

## Structure
- Shared register-map include holds the address constants: `FR_ATR_CTRL`=58, `FR_ATR_TXDLY`=59, `FR_ATR_RXDLY`=60, `FR_ATR_MASK_0..1`=61/64, `FR_ATR_TXVAL_0..1`=62/65, `FR_ATR_RXVAL_0..1`=63/66, `FR_ATR_MAN_0..1`=67/68.
- The same include holds the state encodings.
- One sub-module: `atr_delay_fsm`. It contains the FSM plus the delay counter, with inputs `tx_req`, `enable`, `txdly`, `rxdly` and output state.
- The top level holds the register file and the output muxing.

## Test plan
- Reset with no writes → `reg_0`=`reg_1`=0, `atr_state`=0. Write MAN_0 with data 0x00FF_00A5 → `reg_0`=0x00A5 two edges later.
- enable=1, MASK_0=0xFFFF, RXVAL_0=0x0001, TXVAL_0=0x0002, TXDLY=5; raise `tx_active` → `atr_state`=1 for 5 cycles, then 2; `reg_0`=0x0002 one cycle later.
- RXDLY=3; drop `tx_active` in `TX` → 3 cycles in `RX_WAIT` with `reg_0` still 0x0002, then `RX` and 0x0001.
- TXDLY=10; pulse `tx_active` high for 4 cycles → abort to `RX`; `reg_0` never shows 0x0002.
- RXDLY=8; reassert `tx_active` 2 cycles into `RX_WAIT` → `TX` on the next edge; output stays 0x0002 with no glitch.
- MASK_1=0x00F0, MAN_1=0x1234, TXVAL_1=0xFFFF; `force_tx`=1 → `reg_1`=0x12F4. Clear `enable` → `reg_1`=0x1234.
